// File: rtl/multihPhaseDetPkg.sv
// rtl/multihPhaseDetPkg.sv - shared types, widths and CORDIC arctangent table
//
// Purpose: state encoding, width constants and the 16-entry arctangent table
// (units of 2*pi/65536) used by multih_phase_detector and cordicAtanRom.
// Ports: none (package).
package multihPhaseDetPkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IN_W  = 18;  // input sample width
  localparam int EXT_W = 20;  // internal x/y width, headroom for negation and gain
  localparam int Z_W   = 16;  // angle accumulator width, 2*pi/65536 per LSB
  localparam int PH_W  = 8;   // output phase width, 2*pi/256 per LSB
  localparam int K_W   = 4;   // iteration index width
  localparam int MAG_W = 20;  // magnitude output width

  // round(atan(2^-k) * 65536 / (2*pi)), k = 0..15
  localparam logic [Z_W-1:0] ATAN_TABLE [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
    16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005,
    16'h0003, 16'h0001, 16'h0001, 16'h0000
  };

endpackage

// File: rtl/cordicAtanRom.sv
// rtl/cordicAtanRom.sv - combinational arctangent lookup for the CORDIC engine
//
// Purpose: maps iteration index k to atan(2^-k) in units of 2*pi/65536.
// Ports:
//   k    in  [3:0]  iteration index
//   atan out [15:0] arctangent of 2^-k
module cordicAtanRom
  import multihPhaseDetPkg::*;
(
  input  logic [K_W-1:0] k,
  output logic [Z_W-1:0] atan
);

  assign atan = ATAN_TABLE[k];

endmodule

// File: rtl/multih_phase_detector.sv
// rtl/multih_phase_detector.sv - iterative CORDIC phase detector for the multi-h carrier loop
//
// Purpose: vectors each I/Q symbol sample with one CORDIC micro-rotation per
// clock, rounds the angle to 8 bits and subtracts the trellis reference phase.
// Optional feature macro: MULTIH_PHASE_MAG_GATE_EN (magnitude-gated validity).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   symEn                symbol strobe qualifying iIn/qIn/refPhase
//   iIn, qIn    [17:0]   signed sample, 1.0 = 131072
//   refPhase    [7:0]    expected phase, 2*pi/256 units
//   magThreshold[15:0]   validity threshold vs magnitude[19:4]
//   phaseError  [7:0]    signed phase error
//   phaseErrorEn         one-cycle new-result pulse
//   phaseErrorValid      reliability flag, qualified by phaseErrorEn
//   magnitude   [19:0]   CORDIC x result (includes gain ~1.6468)
//   busy                 engine processing a sample
//   overrunCount[7:0]    saturating count of dropped strobes
module multih_phase_detector
  import multihPhaseDetPkg::*;
#(
  parameter int ITER = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             symEn,
  input  logic [IN_W-1:0]  iIn,
  input  logic [IN_W-1:0]  qIn,
  input  logic [PH_W-1:0]  refPhase,
  input  logic [15:0]      magThreshold,
  output logic [PH_W-1:0]  phaseError,
  output logic             phaseErrorEn,
  output logic             phaseErrorValid,
  output logic [MAG_W-1:0] magnitude,
  output logic             busy,
  output logic [7:0]       overrunCount
);

  localparam logic [K_W-1:0] K_LAST = K_W'(ITER - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [EXT_W-1:0] x;
  logic signed [EXT_W-1:0] y;
  logic [Z_W-1:0]          z;
  logic [K_W-1:0]          k;
  logic [PH_W-1:0]         ref_q;
  logic                    zero_q;

  logic [Z_W-1:0]          atan_k;
  logic signed [EXT_W-1:0] i_ext;
  logic signed [EXT_W-1:0] q_ext;
  logic                    i_neg;
  logic signed [EXT_W-1:0] x_rot;
  logic signed [EXT_W-1:0] y_rot;
  logic [Z_W-1:0]          z_rot;
  logic [PH_W-1:0]         phase;
  logic                    valid_nxt;

  cordicAtanRom u_atan_rom (
    .k    (k),
    .atan (atan_k)
  );

  // 20-bit extension lets -131072 be negated without overflow.
  assign i_ext = {{(EXT_W-IN_W){iIn[IN_W-1]}}, iIn};
  assign q_ext = {{(EXT_W-IN_W){qIn[IN_W-1]}}, qIn};
  assign i_neg = i_ext[EXT_W-1];

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (symEn) state_nxt = ST_ROT;
      ST_ROT:  if (k == K_LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One micro-rotation; both updates use the pre-rotation x and y.
  always_comb begin
    x_rot = x;
    y_rot = y;
    z_rot = z;
    if (!y[EXT_W-1]) begin
      x_rot = x + (y >>> k);
      y_rot = y - (x >>> k);
      z_rot = z + atan_k;
    end else begin
      x_rot = x - (y >>> k);
      y_rot = y + (x >>> k);
      z_rot = z - atan_k;
    end
  end

  // A zero vector would otherwise accumulate the full atan sum (y stays 0,
  // so every step rotates positively); force its phase to 0 instead.
  always_comb begin
    phase = z[Z_W-1:Z_W-PH_W] + {{(PH_W-1){1'b0}}, z[Z_W-PH_W-1]};
    if (zero_q) phase = '0;
  end

`ifdef MULTIH_PHASE_MAG_GATE_EN
  assign valid_nxt = (x[EXT_W-1:4] >= magThreshold);
`else
  logic unused_mag_threshold;
  assign unused_mag_threshold = &{1'b0, magThreshold};
  assign valid_nxt = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      x               <= '0;
      y               <= '0;
      z               <= '0;
      k               <= '0;
      ref_q           <= '0;
      zero_q          <= 1'b0;
      phaseError      <= '0;
      phaseErrorEn    <= 1'b0;
      phaseErrorValid <= 1'b0;
      magnitude       <= '0;
      overrunCount    <= '0;
    end else begin
      state        <= state_nxt;
      phaseErrorEn <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (symEn) begin
            x      <= i_neg ? -i_ext : i_ext;
            y      <= i_neg ? -q_ext : q_ext;
            z      <= i_neg ? 16'h8000 : 16'h0000;
            k      <= '0;
            ref_q  <= refPhase;
            zero_q <= (iIn == '0) && (qIn == '0);
          end
        end
        ST_ROT: begin
          x <= x_rot;
          y <= y_rot;
          z <= z_rot;
          k <= k + K_W'(1);
        end
        ST_DONE: begin
          phaseError      <= phase - ref_q;
          magnitude       <= x;
          phaseErrorValid <= valid_nxt;
          phaseErrorEn    <= 1'b1;
        end
        default: ;
      endcase
      if (symEn && (state != ST_IDLE) && (overrunCount != 8'hFF))
        overrunCount <= overrunCount + 8'd1;
    end
  end

endmodule
